// File: rtl/race_game_multi.sv
// Click-race game engine for PLAYERS players sharing one red/green light.
// Tracks per-player clicks, track position and finishing place (ties share a place).
module race_game_multi #(
  parameter int PLAYERS = 4,
  parameter int CLICK_W = 5,
  parameter int STEP_W  = 3,
  parameter int PENALTY = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        enable,
  input  logic                        red,
  input  logic [PLAYERS-1:0]          click,
  input  logic [CLICK_W-1:0]          max_clicks,
  input  logic [STEP_W-1:0]           max_steps,
  output logic [PLAYERS*STEP_W-1:0]   position,
  output logic [PLAYERS*4-1:0]        status,
  output logic                        running,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_n;
  logic [PLAYERS-1:0]   click_q, edges, locked;
  logic [CLICK_W-1:0]   clicks_r [PLAYERS];
  logic [CLICK_W-1:0]   clicks_n [PLAYERS];
  logic [STEP_W-1:0]    pos_r [PLAYERS];
  logic [STEP_W-1:0]    pos_n [PLAYERS];
  logic [3:0]           stat_r [PLAYERS];
  logic [3:0]           stat_n [PLAYERS];
  logic [2:0]           place_r, place_n;
  logic [CLICK_W-1:0]   mc_r, mc_n;
  logic [STEP_W-1:0]    ms_r, ms_n;
  logic [CLICK_W:0]     cinc;
  logic [STEP_W-1:0]    pinc;
  logic [3:0]           fin_cnt, psum;

  assign edges = click & ~click_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (&locked) state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
    for (int unsigned i = 0; i < PLAYERS; i++) begin
      locked[i]                    = stat_r[i][3];
      position[i*STEP_W +: STEP_W] = pos_r[i];
      status[i*4 +: 4]             = stat_r[i];
    end
  end

  // Next-state datapath; all players evaluated in parallel, finishers this cycle share place_r.
  always_comb begin
    clicks_n = clicks_r;
    pos_n    = pos_r;
    stat_n   = stat_r;
    mc_n     = mc_r;
    ms_n     = ms_r;
    cinc     = '0;
    pinc     = '0;
    fin_cnt  = '0;
    if (state != RUN) begin
      if (start) begin
        for (int unsigned i = 0; i < PLAYERS; i++) begin
          clicks_n[i] = '0;
          pos_n[i]    = '0;
          stat_n[i]   = 4'b0000;
        end
        mc_n = (max_clicks == '0) ? CLICK_W'(1) : max_clicks;
        ms_n = (max_steps == '0) ? STEP_W'(1) : max_steps;
      end
    end else begin
      for (int unsigned i = 0; i < PLAYERS; i++) begin
        if (edges[i] && enable && !stat_r[i][3]) begin
          if (red) begin
            if (PENALTY == 0) begin
              stat_n[i] = 4'b1000;
            end else begin
              clicks_n[i] = '0;
              pos_n[i]    = '0;
            end
          end else begin
            cinc = {1'b0, clicks_r[i]} + 1'b1;
            if (cinc == {1'b0, mc_r}) begin
              clicks_n[i] = '0;
              pinc        = pos_r[i] + STEP_W'(1);
              pos_n[i]    = pinc;
              if (pinc == ms_r) begin
                stat_n[i] = {1'b1, place_r};
                fin_cnt   = fin_cnt + 4'd1;
              end
            end else begin
              clicks_n[i] = cinc[CLICK_W-1:0];
            end
          end
        end
      end
    end
    psum    = {1'b0, place_r} + fin_cnt;
    place_n = (psum > 4'd7) ? 3'd7 : psum[2:0];
    if (state != RUN && start) place_n = 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PLAYERS; i++) begin
        clicks_r[i] <= '0;
        pos_r[i]    <= '0;
        stat_r[i]   <= 4'b1000;
      end
      place_r <= 3'd1;
      mc_r    <= CLICK_W'(1);
      ms_r    <= STEP_W'(1);
      click_q <= '0;
    end else begin
      clicks_r <= clicks_n;
      pos_r    <= pos_n;
      stat_r   <= stat_n;
      place_r  <= place_n;
      mc_r     <= mc_n;
      ms_r     <= ms_n;
      click_q  <= click;
    end
  end

endmodule
